// File: rtl/tlb_pkg.sv
// -----------------------------------------------------------------------------
// tlb_pkg
// Shared definitions for the CP0 TLB controller: operation encodings, FSM
// states, packed-entry field positions and the EntryHi/EntryLo -> entry
// packing helper.
// -----------------------------------------------------------------------------
package tlb_pkg;

    localparam int NUM_ENTRIES = 16;
    localparam int ENTRY_W     = 80;
    localparam int IDX_W       = 4;

    // Packed entry layout, MSB first:
    // ASID | G | VPN2 | PFN1 | D1 | V1 | PFN0 | D0 | V0
    localparam int ASID_HI = 79;
    localparam int ASID_LO = 72;
    localparam int G_BIT   = 71;
    localparam int VPN2_HI = 70;
    localparam int VPN2_LO = 52;
    localparam int PFN1_HI = 51;
    localparam int PFN1_LO = 28;
    localparam int D1_BIT  = 27;
    localparam int V1_BIT  = 26;
    localparam int PFN0_HI = 25;
    localparam int PFN0_LO = 2;
    localparam int D0_BIT  = 1;
    localparam int V0_BIT  = 0;

    typedef logic [ENTRY_W-1:0]          tlb_entry_t;
    typedef tlb_entry_t [NUM_ENTRIES-1:0] tlb_array_t;

    typedef enum logic [1:0] {
        TLB_OP_TLBR  = 2'd0,
        TLB_OP_TLBWI = 2'd1,
        TLB_OP_TLBWR = 2'd2,
        TLB_OP_TLBP  = 2'd3
    } tlb_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } tlb_state_e;

    // Build an array entry from the CP0 register images. The global bit is
    // only set when both halves of the pair are marked global.
    function automatic tlb_entry_t pack_entry(input logic [31:0] hi,
                                              input logic [31:0] lo0,
                                              input logic [31:0] lo1);
        tlb_entry_t e;
        e                    = '0;
        e[ASID_HI:ASID_LO]   = hi[7:0];
        e[G_BIT]             = lo0[0] & lo1[0];
        e[VPN2_HI:VPN2_LO]   = hi[31:13];
        e[PFN1_HI:PFN1_LO]   = lo1[29:6];
        e[D1_BIT]            = lo1[2];
        e[V1_BIT]            = lo1[1];
        e[PFN0_HI:PFN0_LO]   = lo0[29:6];
        e[D0_BIT]            = lo0[2];
        e[V0_BIT]            = lo0[1];
        return e;
    endfunction

endpackage

// File: rtl/tlb_probe_match.sv
// -----------------------------------------------------------------------------
// tlb_probe_match
// Combinational associative search over the TLB array. An entry matches when
// its VPN2 equals the probe VPN2 and either its ASID equals the probe ASID or
// it is global. The lowest matching index wins.
//   entries_i : all packed entries
//   vpn2_i    : probe VPN2
//   asid_i    : probe ASID
//   hit_o     : at least one entry matched
//   idx_o     : lowest matching index (0 when no hit)
// -----------------------------------------------------------------------------
module tlb_probe_match
    import tlb_pkg::*;
(
    input  tlb_array_t        entries_i,
    input  logic [18:0]       vpn2_i,
    input  logic [7:0]        asid_i,
    output logic              hit_o,
    output logic [IDX_W-1:0]  idx_o
);

    // NOTE: every output of an always_comb gets a default before any branch,
    // otherwise paths that skip an assignment infer a latch.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        // Scan downwards so the last assignment made is the lowest index.
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (entries_i[i][VPN2_HI:VPN2_LO] == vpn2_i &&
                (entries_i[i][ASID_HI:ASID_LO] == asid_i || entries_i[i][G_BIT])) begin
                hit_o = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/tlb_ctrl.sv
// -----------------------------------------------------------------------------
// tlb_ctrl
// Owns the 16-entry TLB array and executes TLBR/TLBWI/TLBWR/TLBP through an
// IDLE -> EXEC -> RESP command FSM. Maintains Random and Wired, and exports
// every entry continuously to the translation lookup.
//   clk, rst_n                 : clock, synchronous active-low reset
//   cmd_valid/cmd_ready/cmd_op : command handshake and operation
//   index_in, entryhi_in,
//   entrylo0_in, entrylo1_in   : CP0 operand registers, captured on accept
//   wired_we, wired_in         : Wired update (also reloads Random)
//   done                       : one-cycle completion pulse (RESP state)
//   rd_entryhi/lo0/lo1         : TLBR results, held until the next TLBR
//   probe_miss, probe_idx      : TLBP results, held until the next TLBP
//   random_out, wired_out      : current Random / Wired
//   tlb_entry0..15             : packed entries
// -----------------------------------------------------------------------------
module tlb_ctrl
    import tlb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [3:0]         index_in,
    input  logic [31:0]        entryhi_in,
    input  logic [31:0]        entrylo0_in,
    input  logic [31:0]        entrylo1_in,
    input  logic               wired_we,
    input  logic [3:0]         wired_in,
    output logic               done,
    output logic [31:0]        rd_entryhi,
    output logic [31:0]        rd_entrylo0,
    output logic [31:0]        rd_entrylo1,
    output logic               probe_miss,
    output logic [3:0]         probe_idx,
    output logic [3:0]         random_out,
    output logic [3:0]         wired_out,
    output logic [ENTRY_W-1:0] tlb_entry0,
    output logic [ENTRY_W-1:0] tlb_entry1,
    output logic [ENTRY_W-1:0] tlb_entry2,
    output logic [ENTRY_W-1:0] tlb_entry3,
    output logic [ENTRY_W-1:0] tlb_entry4,
    output logic [ENTRY_W-1:0] tlb_entry5,
    output logic [ENTRY_W-1:0] tlb_entry6,
    output logic [ENTRY_W-1:0] tlb_entry7,
    output logic [ENTRY_W-1:0] tlb_entry8,
    output logic [ENTRY_W-1:0] tlb_entry9,
    output logic [ENTRY_W-1:0] tlb_entry10,
    output logic [ENTRY_W-1:0] tlb_entry11,
    output logic [ENTRY_W-1:0] tlb_entry12,
    output logic [ENTRY_W-1:0] tlb_entry13,
    output logic [ENTRY_W-1:0] tlb_entry14,
    output logic [ENTRY_W-1:0] tlb_entry15
);

    tlb_state_e       state_q, state_d;
    tlb_op_e          op_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] rand_cap_q;
    tlb_entry_t       cmd_entry_q;   // operands pre-packed in entry layout
    logic [IDX_W-1:0] random_q, random_d;
    logic [IDX_W-1:0] wired_q;
    tlb_array_t       entries_q;

    logic [31:0]      rd_entryhi_q, rd_entrylo0_q, rd_entrylo1_q;
    logic             probe_miss_q;
    logic [IDX_W-1:0] probe_idx_q;

    logic             accept;
    logic             probe_hit;
    logic [IDX_W-1:0] probe_hit_idx;
    tlb_entry_t       rd_sel;
    logic [IDX_W-1:0] wr_idx;

    // Operand bits with no home in the entry format.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{entryhi_in[12:8],
                                   entrylo0_in[31:30], entrylo0_in[5:3],
                                   entrylo1_in[31:30], entrylo1_in[5:3]};

    // ---------------- Command FSM: next state and handshake outputs ----------
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = ST_EXEC;
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept = cmd_valid & cmd_ready;

    // ---------------- Random ---------------------------------------------------
    // Counts down through [Wired, 15]; also wraps from 0 so a Wired of 0 still
    // cycles through every entry. A Wired write restarts the count at the top.
    always_comb begin
        if (wired_we)
            random_d = 4'd15;
        else if (random_q == wired_q || random_q == 4'd0)
            random_d = 4'd15;
        else
            random_d = random_q - 4'd1;
    end

    // ---------------- Datapath helpers ----------------------------------------
    tlb_probe_match u_probe (
        .entries_i (entries_q),
        .vpn2_i    (cmd_entry_q[VPN2_HI:VPN2_LO]),
        .asid_i    (cmd_entry_q[ASID_HI:ASID_LO]),
        .hit_o     (probe_hit),
        .idx_o     (probe_hit_idx)
    );

    assign rd_sel = entries_q[idx_q];
    assign wr_idx = (op_q == TLB_OP_TLBWR) ? rand_cap_q : idx_q;

    // ---------------- State ----------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            op_q          <= TLB_OP_TLBR;
            idx_q         <= '0;
            rand_cap_q    <= '0;
            cmd_entry_q   <= '0;
            random_q      <= 4'd15;
            wired_q       <= '0;
            // NOTE: the array is flops, not RAM: all entries are exported in
            // parallel, so clearing it on reset costs no extra write ports.
            entries_q     <= '0;
            rd_entryhi_q  <= '0;
            rd_entrylo0_q <= '0;
            rd_entrylo1_q <= '0;
            probe_miss_q  <= 1'b1;
            probe_idx_q   <= '0;
        end else begin
            state_q  <= state_d;
            random_q <= random_d;
            if (wired_we) wired_q <= wired_in;

            // Random is captured before this edge's update, so a concurrent
            // Wired write does not disturb the TLBWR target.
            if (accept) begin
                op_q        <= tlb_op_e'(cmd_op);
                idx_q       <= index_in;
                rand_cap_q  <= random_q;
                cmd_entry_q <= pack_entry(entryhi_in, entrylo0_in, entrylo1_in);
            end

            if (state_q == ST_EXEC) begin
                unique case (op_q)
                    TLB_OP_TLBR: begin
                        rd_entryhi_q  <= {rd_sel[VPN2_HI:VPN2_LO], 5'b0, rd_sel[ASID_HI:ASID_LO]};
                        rd_entrylo0_q <= {2'b0, rd_sel[PFN0_HI:PFN0_LO], 3'b0,
                                          rd_sel[D0_BIT], rd_sel[V0_BIT], rd_sel[G_BIT]};
                        rd_entrylo1_q <= {2'b0, rd_sel[PFN1_HI:PFN1_LO], 3'b0,
                                          rd_sel[D1_BIT], rd_sel[V1_BIT], rd_sel[G_BIT]};
                    end
                    TLB_OP_TLBWI, TLB_OP_TLBWR: begin
                        entries_q[wr_idx] <= cmd_entry_q;
                    end
                    TLB_OP_TLBP: begin
                        probe_miss_q <= ~probe_hit;
                        probe_idx_q  <= probe_hit ? probe_hit_idx : '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- Outputs ------------------------------------------------
    assign rd_entryhi  = rd_entryhi_q;
    assign rd_entrylo0 = rd_entrylo0_q;
    assign rd_entrylo1 = rd_entrylo1_q;
    assign probe_miss  = probe_miss_q;
    assign probe_idx   = probe_idx_q;
    assign random_out  = random_q;
    assign wired_out   = wired_q;

    assign tlb_entry0  = entries_q[0];
    assign tlb_entry1  = entries_q[1];
    assign tlb_entry2  = entries_q[2];
    assign tlb_entry3  = entries_q[3];
    assign tlb_entry4  = entries_q[4];
    assign tlb_entry5  = entries_q[5];
    assign tlb_entry6  = entries_q[6];
    assign tlb_entry7  = entries_q[7];
    assign tlb_entry8  = entries_q[8];
    assign tlb_entry9  = entries_q[9];
    assign tlb_entry10 = entries_q[10];
    assign tlb_entry11 = entries_q[11];
    assign tlb_entry12 = entries_q[12];
    assign tlb_entry13 = entries_q[13];
    assign tlb_entry14 = entries_q[14];
    assign tlb_entry15 = entries_q[15];

endmodule

// File: tb/tb_tlb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tlb_ctrl
// Directed bench for tlb_ctrl. Inputs change on the falling edge, outputs are
// sampled on the falling edge. Expected entries and register images are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_tlb_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  index_in;
    logic [31:0] entryhi_in, entrylo0_in, entrylo1_in;
    logic        wired_we;
    logic [3:0]  wired_in;
    logic        done;
    logic [31:0] rd_entryhi, rd_entrylo0, rd_entrylo1;
    logic        probe_miss;
    logic [3:0]  probe_idx;
    logic [3:0]  random_out, wired_out;
    logic [79:0] ent [16];

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [1:0] OP_R  = 2'd0;
    localparam logic [1:0] OP_WI = 2'd1;
    localparam logic [1:0] OP_WR = 2'd2;
    localparam logic [1:0] OP_P  = 2'd3;

    localparam logic [79:0] E5  = {8'h12, 1'b1, 19'h00201, 24'h2, 1'b1, 1'b1, 24'h1, 1'b1, 1'b1};
    localparam logic [79:0] E2  = {8'hFF, 1'b0, 19'h00201, 24'h3, 1'b1, 1'b1, 24'h2, 1'b1, 1'b1};
    localparam logic [79:0] E13 = {8'h05, 1'b0, 19'h00002, 24'h5, 1'b0, 1'b1, 24'h4, 1'b1, 1'b0};
    localparam logic [79:0] E1  = {8'h44, 1'b1, 19'h00003, 24'h7, 1'b1, 1'b0, 24'h6, 1'b0, 1'b1};

    tlb_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .index_in    (index_in),
        .entryhi_in  (entryhi_in),
        .entrylo0_in (entrylo0_in),
        .entrylo1_in (entrylo1_in),
        .wired_we    (wired_we),
        .wired_in    (wired_in),
        .done        (done),
        .rd_entryhi  (rd_entryhi),
        .rd_entrylo0 (rd_entrylo0),
        .rd_entrylo1 (rd_entrylo1),
        .probe_miss  (probe_miss),
        .probe_idx   (probe_idx),
        .random_out  (random_out),
        .wired_out   (wired_out),
        .tlb_entry0  (ent[0]),
        .tlb_entry1  (ent[1]),
        .tlb_entry2  (ent[2]),
        .tlb_entry3  (ent[3]),
        .tlb_entry4  (ent[4]),
        .tlb_entry5  (ent[5]),
        .tlb_entry6  (ent[6]),
        .tlb_entry7  (ent[7]),
        .tlb_entry8  (ent[8]),
        .tlb_entry9  (ent[9]),
        .tlb_entry10 (ent[10]),
        .tlb_entry11 (ent[11]),
        .tlb_entry12 (ent[12]),
        .tlb_entry13 (ent[13]),
        .tlb_entry14 (ent[14]),
        .tlb_entry15 (ent[15])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Called at a falling edge; returns at the falling edge of the EXEC cycle.
    task automatic issue(input logic [1:0] op, input logic [3:0] idx,
                         input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
        int n;
        n           = 0;
        cmd_valid   = 1'b1;
        cmd_op      = op;
        index_in    = idx;
        entryhi_in  = hi;
        entrylo0_in = lo0;
        entrylo1_in = lo1;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("accept_timeout", 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Counts falling edges until done is seen; bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!done) check("done_timeout", 1'b0, 1'b1);
    endtask

    // Issue, expect done on the cycle after EXEC, then step back to IDLE.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] idx,
                           input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
        int lat;
        issue(op, idx, hi, lo0, lo1);
        wait_done(lat);
        check({tag, "_done_lat"}, 80'(lat), 80'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 80'(done), 80'd0);
    endtask

    initial begin
        logic [79:0] acc;
        int          lat;

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        index_in    = '0;
        entryhi_in  = '0;
        entrylo0_in = '0;
        entrylo1_in = '0;
        wired_we    = 1'b0;
        wired_in    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // ---- 1. Reset state ----
        acc = '0;
        for (int i = 0; i < 16; i++) acc = acc | ent[i];
        check("rst_ready",  80'(cmd_ready),  80'd1);
        check("rst_done",   80'(done),       80'd0);
        check("rst_random", 80'(random_out), 80'd15);
        check("rst_wired",  80'(wired_out),  80'd0);
        check("rst_entries", acc, 80'd0);
        check("rst_pmiss",  80'(probe_miss), 80'd1);
        check("rst_pidx",   80'(probe_idx),  80'd0);
        check("rst_rdhi",   80'(rd_entryhi), 80'd0);

        // Random with Wired = 0: 15 down to 0, then wrap to 15.
        repeat (15) @(negedge clk);
        check("rand_zero", 80'(random_out), 80'd0);
        @(negedge clk);
        check("rand_wrap0", 80'(random_out), 80'd15);

        // ---- 2. TLBWI index 5 ----
        issue(OP_WI, 4'd5, 32'h0040_2012, 32'h0000_0047, 32'h0000_0087);
        check("wi_exec_done",  80'(done),      80'd0);
        check("wi_exec_ready", 80'(cmd_ready), 80'd0);
        check("wi_e5_before",  ent[5],         80'd0);
        wait_done(lat);
        check("wi_done_lat", 80'(lat), 80'd1);
        check("wi_e5", ent[5], E5);
        @(negedge clk);
        check("wi_done_pulse", 80'(done),      80'd0);
        check("wi_ready_back", 80'(cmd_ready), 80'd1);

        // ---- 3. TLBR index 5 ----
        run_cmd("r5", OP_R, 4'd5, 32'h0, 32'h0, 32'h0);
        check("r5_hi",  80'(rd_entryhi),  80'h0040_2012);
        check("r5_lo0", 80'(rd_entrylo0), 80'h0000_0047);
        check("r5_lo1", 80'(rd_entrylo1), 80'h0000_0087);

        // ---- 4. TLBP ----
        run_cmd("p_g", OP_P, 4'd0, 32'h0040_20FF, 32'h0, 32'h0);
        check("p_g_miss", 80'(probe_miss), 80'd0);
        check("p_g_idx",  80'(probe_idx),  80'd5);
        // Same VPN2 at a lower index, non-global, ASID 0xFF.
        run_cmd("wi2", OP_WI, 4'd2, 32'h0040_20FF, 32'h0000_0086, 32'h0000_00C6);
        check("wi2_e2", ent[2], E2);
        run_cmd("p_low", OP_P, 4'd0, 32'h0040_20FF, 32'h0, 32'h0);
        check("p_low_miss", 80'(probe_miss), 80'd0);
        check("p_low_idx",  80'(probe_idx),  80'd2);
        // ASID 0x33 misses entry 2 (not global) but hits global entry 5.
        run_cmd("p_asid", OP_P, 4'd0, 32'h0040_2033, 32'h0, 32'h0);
        check("p_asid_idx", 80'(probe_idx), 80'd5);
        // TLBR results held across a TLBP.
        check("r5_hold", 80'(rd_entrylo1), 80'h0000_0087);
        run_cmd("p_miss", OP_P, 4'd0, 32'hFFFF_E000, 32'h0, 32'h0);
        check("p_miss_miss", 80'(probe_miss), 80'd1);
        check("p_miss_idx",  80'(probe_idx),  80'd0);
        // TLBR of entry 2 (G clear in both halves).
        run_cmd("r2", OP_R, 4'd2, 32'h0, 32'h0, 32'h0);
        check("r2_hi",  80'(rd_entryhi),  80'h0040_20FF);
        check("r2_lo0", 80'(rd_entrylo0), 80'h0000_0086);
        check("r2_lo1", 80'(rd_entrylo1), 80'h0000_00C6);

        // ---- 5. Wired and TLBWR ----
        wired_we = 1'b1;
        wired_in = 4'd12;
        @(negedge clk);
        wired_we = 1'b0;
        check("wired_val", 80'(wired_out),  80'd12);
        check("wired_r15", 80'(random_out), 80'd15);
        @(negedge clk);
        check("wired_r14", 80'(random_out), 80'd14);
        @(negedge clk);
        check("wired_r13", 80'(random_out), 80'd13);
        issue(OP_WR, 4'd0, 32'h0000_4005, 32'h0000_0105, 32'h0000_0142);
        check("wr_r12", 80'(random_out), 80'd12);
        @(negedge clk);
        check("wr_done",  80'(done),       80'd1);
        check("wr_rwrap", 80'(random_out), 80'd15);
        check("wr_e13",   ent[13],         E13);
        check("wr_e12",   ent[12],         80'd0);
        check("wr_e0",    ent[0],          80'd0);
        @(negedge clk);
        check("wr_r14b", 80'(random_out), 80'd14);

        // ---- 6a. Reset during EXEC ----
        @(negedge clk);
        issue(OP_WI, 4'd9, 32'h0040_2012, 32'h0000_0047, 32'h0000_0087);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_done",  80'(done),       80'd0);
        check("mid_rst_ready", 80'(cmd_ready),  80'd1);
        check("mid_rst_e9",    ent[9],          80'd0);
        check("mid_rst_e5",    ent[5],          80'd0);
        check("mid_rst_wired", 80'(wired_out),  80'd0);
        check("mid_rst_rand",  80'(random_out), 80'd15);
        check("mid_rst_pmiss", 80'(probe_miss), 80'd1);
        @(negedge clk);
        check("mid_rst_done2", 80'(done), 80'd0);
        check("mid_rst_e9b",   ent[9],    80'd0);

        // ---- 6b. cmd_valid held across EXEC/RESP ----
        cmd_valid   = 1'b1;
        cmd_op      = OP_WI;
        index_in    = 4'd1;
        entryhi_in  = 32'h0000_6044;
        entrylo0_in = 32'h0000_0183;
        entrylo1_in = 32'h0000_01C5;
        check("hold_ready0", 80'(cmd_ready), 80'd1);
        @(negedge clk);
        check("hold_exec_ready", 80'(cmd_ready), 80'd0);
        check("hold_exec_done",  80'(done),      80'd0);
        @(negedge clk);
        check("hold_resp_ready", 80'(cmd_ready), 80'd0);
        check("hold_resp_done",  80'(done),      80'd1);
        check("hold_e1",         ent[1],         E1);
        @(negedge clk);
        check("hold_idle_ready", 80'(cmd_ready), 80'd1);
        check("hold_idle_done",  80'(done),      80'd0);
        @(negedge clk);
        check("hold_exec2_ready", 80'(cmd_ready), 80'd0);
        cmd_valid = 1'b0;
        wait_done(lat);
        check("hold_done2_lat", 80'(lat), 80'd1);
        @(negedge clk);
        check("hold_final_ready", 80'(cmd_ready), 80'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tlb_ctrl.md
Name: tlb_ctrl

Overview:
Owns the 16-entry MMU TLB array and executes the CP0 TLB instructions (TLBR, TLBWI, TLBWR, TLBP) through a small command FSM with a valid/ready/done handshake. Maintains the Random counter and Wired bound. Drives all 16 packed 80-bit entries continuously to the combinational translation lookup used by the fetch and memory stages. Sits between the CP0 register file and the MMU.

Parameters:
NUM_ENTRIES, 16, number of TLB entries; fixed by the 4-bit index width.
ENTRY_W, 80, packed entry width.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready at a rising edge
cmd_op  in  2  operation: 0 TLBR, 1 TLBWI, 2 TLBWR, 3 TLBP
index_in  in  4  CP0 Index[3:0]
entryhi_in  in  32  CP0 EntryHi: VPN2 [31:13], ASID [7:0]
entrylo0_in  in  32  CP0 EntryLo0: PFN [29:6], D [2], V [1], G [0]
entrylo1_in  in  32  CP0 EntryLo1: same layout as EntryLo0
wired_we  in  1  write Wired
wired_in  in  4  new Wired value
done  out  1  one-cycle pulse on command completion
rd_entryhi  out  32  TLBR result; valid while done is high and held afterwards
rd_entrylo0  out  32  TLBR result
rd_entrylo1  out  32  TLBR result
probe_miss  out  1  TLBP result: 1 means no match (Index.P)
probe_idx  out  4  TLBP matched index; 0 on miss
random_out  out  4  current Random
wired_out  out  4  current Wired
tlb_entry0..tlb_entry15  out  80 each  packed entries: ASID [79:72], G [71], VPN2 [70:52], PFN1 [51:28], D1 [27], V1 [26], PFN0 [25:2], D0 [1], V0 [0]

Behaviour:
- Reset (rst_n low at a rising edge):
  - All entries = 0; random = 15; wired = 0.
  - cmd_ready = 1 and done = 0.
  - rd_* = 0, probe_miss = 1, probe_idx = 0.
  - FSM goes to IDLE. Any in-flight command is discarded without a done pulse.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
  - Accept at edge N: capture cmd_op, index_in, entryhi_in, entrylo0_in, entrylo1_in, and random (the value before that edge's decrement).
  - EXEC occupies cycle N+1. The array update or result registers are written at the end of EXEC.
  - RESP occupies cycle N+2, with done = 1.
  - Next accept is possible at the end of N+3, when IDLE has cmd_ready = 1. Throughput is 1 command per 3 cycles.
  - cmd_valid outside IDLE is ignored; the requester holds it.
- TLBWI / TLBWR write the entry as follows:
  - ASID = EntryHi[7:0]; VPN2 = EntryHi[31:13].
  - G = lo0.G & lo1.G.
  - PFN0/D0/V0 from lo0[29:6]/[2]/[1]; PFN1/D1/V1 from lo1.
  - Target index: TLBWI uses the captured index; TLBWR uses the captured random.
  - The new value is visible on tlb_entryN from cycle N+2.
- TLBR:
  - rd_entryhi = {VPN2, 5'b0, ASID}.
  - rd_entrylo0 = {2'b0, PFN0, 3'b0, D0, V0, G}; rd_entrylo1 likewise with PFN1/D1/V1.
  - G is replicated into both EntryLo values.
- TLBP:
  - Match = entry VPN2 == EntryHi[31:13] && (entry ASID == EntryHi[7:0] || entry G).
  - The lowest-index match wins.
  - No match: probe_miss = 1, probe_idx = 0.
  - Matching is evaluated against the array contents during EXEC.
- Random:
  - Decrements every cycle.
  - If random == wired, or random == 0, the next value is 15 (wrap).
  - wired_we: wired <= wired_in and random <= 15 on the same edge, overriding the decrement.
  - wired_we concurrent with an accept: TLBWR still uses the pre-edge random capture.
- Results (rd_*, probe_*) hold until the next command of the same kind.

Decomposition:
- Package tlb_pkg holds:
  - Op encodings TLB_OP_TLBR/TLBWI/TLBWR/TLBP.
  - Entry field bit positions (ASID_HI/LO, G_BIT, VPN2_HI/LO, PFN1_*, D1, V1, PFN0_*, D0, V0).
  - NUM_ENTRIES and the FSM state encodings.
- Sub-module tlb_probe_match is combinational and reused for TLBP.
  - Inputs: 16 entries, VPN2, ASID.
  - Outputs: hit, lowest matching index.

Test Plan:
1. Reset -> cmd_ready = 1, random_out = 15, wired_out = 0, all tlb_entryN = 0, probe_miss = 1.
2. TLBWI with index = 5, entryhi = 0x0040_2012, lo0 = 0x0000_0047, lo1 = 0x0000_0087 -> done pulses 2 cycles after accept. tlb_entry5 = {8'h12, 1'b1, 19'h00201, 24'h2, 1'b1, 1'b1, 24'h1, 1'b1, 1'b1}.
3. After test 2, TLBR index = 5 -> rd_entryhi = 0x0040_2012, rd_entrylo0 = 0x0000_0047, rd_entrylo1 = 0x0000_0087.
4. TLBP with entryhi = 0x0040_20FF (G set) -> probe_miss = 0, probe_idx = 5. Then write the same VPN2 to index 2 and repeat the probe -> probe_idx = 2. A probe with VPN2 0x7FFFF -> probe_miss = 1, probe_idx = 0.
5. wired_we with wired_in = 12 -> random = 15 next cycle, then 14, 13, 12, 15, 14, … Issue TLBWR while random = 13 at accept -> entry 13 is written.
6. Deassert rst_n during EXEC of a TLBWI -> no done pulse, target entry stays 0, cmd_ready = 1 after reset. Also: cmd_valid held during EXEC/RESP -> second command accepted only after returning to IDLE.
